gate_bank_sweeper: RTL and testbench

Sequential stimulus-and-check stage that drives the two-input mux-based gate bank (`a`, `b` → `y[0:6]`) and checks every output. On `start` it walks {a,b} through all four combinations for a configurable number of passes. After a settle interval it samples the bank's 7-bit output vector and compares it against an internal golden model. It then reports pass/fail, a mismatch count and the first failing pattern. It sits directly upstream of the gate bank, which it feeds, and directly downstream of it, since it consumes the bank's output.

---
 rtl/gate_sweep_pkg.sv | 13 +
 rtl/gate_expect.sv | 22 ++
 rtl/gate_bank_sweeper.sv | 101 ++++++++++
 tb/tb_gate_bank_sweeper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared states, widths and gate bit positions for the gate bank sweeper
package gate_sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int pat_w = 2;
    localparam int vec_w = 7;
    localparam int y_not  = 0;
    localparam int y_and  = 1;
    localparam int y_or   = 2;
    localparam int y_nand = 3;
    localparam int y_nor  = 4;
    localparam int y_xor  = 5;
    localparam int y_xnor = 6;
endpackage

// File: rtl/gate_expect.sv
// gate_expect: golden gate-bank vector for an {a,b} pattern, same bit order as y_in
module gate_expect
    import gate_sweep_pkg::*;
(
    input  logic [pat_w-1:0] pat,
    output logic [0:vec_w-1] vec
);
    logic a, b;
    assign a = pat[1];
    assign b = pat[0];
    // truth table of every gate for the current operands
    always_comb begin
        vec = '0;
        vec[y_not]  = ~a;
        vec[y_and]  = a & b;
        vec[y_or]   = a | b;
        vec[y_nand] = ~(a & b);
        vec[y_nor]  = ~(a | b);
        vec[y_xor]  = a ^ b;
        vec[y_xnor] = ~(a ^ b);
    end
endmodule

// File: rtl/gate_bank_sweeper.sv
// gate_bank_sweeper: drives all {a,b} patterns into the gate bank and checks y_in; GATE_SWEEP_LOG_EN builds err_log
module gate_bank_sweeper
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int PASSES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [0:vec_w-1] y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [1:0]       first_fail_pat,
    output logic [0:vec_w-1] first_fail_vec,
    output logic [3:0]       err_log
);
    state_t           state, state_nx;
    logic [3:0]       cnt, pcnt;
    logic [1:0]       pat;
    logic [0:vec_w-1] exp_vec, diff;
    logic             go, mis, last, settled, sampling;

    gate_expect u_exp (.pat(pat), .vec(exp_vec));

    assign a_out    = pat[1];
    assign b_out    = pat[0];
    assign go       = state == IDLE && start && !abort;
    assign diff     = exp_vec ^ y_in;
    assign mis      = |diff;
    assign sampling = state == SAMPLE && !abort;
    assign settled  = cnt == 4'(SETTLE - 1);
    assign last     = pat == 2'd3 && pcnt == 4'(PASSES - 1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state with abort overriding every transition, plus status decode
    always_comb begin
        state_nx = abort ? IDLE :
                   state == IDLE   ? (start ? DRIVE : IDLE) :
                   state == DRIVE  ? (settled ? SAMPLE : DRIVE) :
                   state == SAMPLE ? (last ? DONE : DRIVE) : IDLE;
        busy = state == DRIVE || state == SAMPLE;
        done = state == DONE;
    end

    // settle/pattern/pass counters and result capture; start clears, abort freezes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            pcnt           <= '0;
            pat            <= '0;
            err_cnt        <= '0;
            first_fail_pat <= '0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
        end else if (go) begin
            cnt            <= '0;
            pcnt           <= '0;
            pat            <= '0;
            err_cnt        <= '0;
            first_fail_pat <= '0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
        end else if (!abort) begin
            if (state == DRIVE) cnt <= settled ? 4'd0 : cnt + 4'd1;
            if (state == SAMPLE) begin
                if (mis && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                if (mis && err_cnt == 8'd0) begin
                    first_fail_pat <= pat;
                    first_fail_vec <= diff;
                end
                if (last) pass <= err_cnt == 8'd0 && !mis;
                else begin
                    pat <= pat + 2'd1;
                    if (pat == 2'd3) pcnt <= pcnt + 4'd1;
                end
            end
        end
    end

`ifdef GATE_SWEEP_LOG_EN
    // sticky per-pattern mismatch bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 err_log      <= '0;
        else if (go)             err_log      <= '0;
        else if (sampling && mis) err_log[pat] <= 1'b1;
    end
`else
    assign err_log = '0;
`endif
endmodule

// File: tb/tb_gate_bank_sweeper.sv
// tb_gate_bank_sweeper: randomized fault-injection bench with a behavioural gate-bank model
module tb_gate_bank_sweeper;
    logic clk = 0, rst = 1, abort = 0, start1 = 0, start2 = 0;
    logic [0:6] clr = '0, set = '0, y1, y2, ffv1, ffv2;
    logic a1, b1, busy1, done1, pass1, a2, b2, busy2, done2, pass2;
    logic [7:0] ec1, ec2;
    logic [1:0] ffp1, ffp2;
    logic [3:0] log1, log2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    function automatic logic [0:6] gold(input logic a, input logic b);
        return {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    assign y1 = (gold(a1, b1) & ~clr) | set;
    assign y2 = (gold(a2, b2) & ~clr) | set;

    gate_bank_sweeper dut (.clk(clk), .rst(rst), .start(start1), .abort(abort), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1),
        .first_fail_pat(ffp1), .first_fail_vec(ffv1), .err_log(log1));

    gate_bank_sweeper #(.SETTLE(2), .PASSES(3)) dut2 (.clk(clk), .rst(rst), .start(start2),
        .abort(abort), .y_in(y2), .a_out(a2), .b_out(b2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(ec2), .first_fail_pat(ffp2), .first_fail_vec(ffv2), .err_log(log2));

    function automatic void model(input logic [0:6] c, input logic [0:6] s, input int passes,
                                  output int ec, output logic [1:0] fp, output logic [0:6] fv,
                                  output logic [3:0] lg);
        logic [0:6] e, g;
        logic [1:0] ab;
        ec = 0; fp = 0; fv = 0; lg = 0;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < 4; i++) begin
                ab = 2'(i);
                e = gold(ab[1], ab[0]);
                g = (e & ~c) | s;
                if (g !== e) begin
                    if (ec == 0) begin fp = ab; fv = e ^ g; end
                    if (ec < 255) ec++;
                    lg[i] = 1'b1;
                end
            end
`ifndef GATE_SWEEP_LOG_EN
        lg = 0;
`endif
    endfunction

    task automatic go1(output int n);
        @(negedge clk); @(negedge clk); start1 = 1;
        @(posedge clk); #1 start1 = 0;
        n = 0;
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
    endtask

    task automatic go2(output int n);
        @(negedge clk); @(negedge clk); start2 = 1;
        @(posedge clk); #1 start2 = 0;
        n = 0;
        while (!done2 && n < 300) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({a1, b1, busy1, done1, pass1, ec1, ffp1, ffv1, log1} !== '0) begin
            errors++; $display("FAIL reset_dut1 got=%h exp=0", {a1, b1, busy1, done1, pass1, ec1, ffp1, ffv1, log1}); end
        checks++; if ({a2, b2, busy2, done2, pass2, ec2, ffp2, ffv2, log2} !== '0) begin
            errors++; $display("FAIL reset_dut2 got=%h exp=0", {a2, b2, busy2, done2, pass2, ec2, ffp2, ffv2, log2}); end
        @(negedge clk) rst = 0;
    endtask

    task automatic test_clean;
        int n;
        clr = '0; set = '0;
        @(negedge clk); start1 = 1;
        @(posedge clk); #1 start1 = 0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_rise got=%b exp=1", busy1); end
        n = 0;
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL clean_done_edge got=%0d exp=8", n); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL busy_fall got=%b exp=0", busy1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL clean_pass got=%b exp=1", pass1); end
        checks++; if (ec1 !== 8'd0) begin errors++; $display("FAIL clean_errcnt got=%0d exp=0", ec1); end
        checks++; if (log1 !== 4'b0000) begin errors++; $display("FAIL clean_log got=%b exp=0000", log1); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", done1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL pass_hold got=%b exp=1", pass1); end
    endtask

    task automatic test_xor_stuck;
        int n;
        clr = 7'b0000010; set = '0;
        go1(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL xor_done_edge got=%0d exp=8", n); end
        checks++; if (ec1 !== 8'd2) begin errors++; $display("FAIL xor_errcnt got=%0d exp=2", ec1); end
        checks++; if (ffp1 !== 2'b01) begin errors++; $display("FAIL xor_ffpat got=%b exp=01", ffp1); end
        checks++; if (ffv1 !== 7'b0000010) begin errors++; $display("FAIL xor_ffvec got=%b exp=0000010", ffv1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL xor_pass got=%b exp=0", pass1); end
`ifdef GATE_SWEEP_LOG_EN
        checks++; if (log1 !== 4'b0110) begin errors++; $display("FAIL xor_log got=%b exp=0110", log1); end
`else
        checks++; if (log1 !== 4'b0000) begin errors++; $display("FAIL xor_log got=%b exp=0000", log1); end
`endif
    endtask

    task automatic test_params;
        int n;
        clr = '0; set = 7'b1000000;
        go2(n);
        checks++; if (n !== 36) begin errors++; $display("FAIL p3s2_done_edge got=%0d exp=36", n); end
        checks++; if (ec2 !== 8'd6) begin errors++; $display("FAIL p3s2_errcnt got=%0d exp=6", ec2); end
        checks++; if (ffp2 !== 2'b10) begin errors++; $display("FAIL p3s2_ffpat got=%b exp=10", ffp2); end
        checks++; if (ffv2 !== 7'b1000000) begin errors++; $display("FAIL p3s2_ffvec got=%b exp=1000000", ffv2); end
        checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL p3s2_pass got=%b exp=0", pass2); end
    endtask

    task automatic test_random;
        int n, ec;
        logic [1:0] fp;
        logic [0:6] fv;
        logic [3:0] lg;
        for (int it = 0; it < 8; it++) begin
            clr = (it % 3 == 0) ? '0 : 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
            set = (it % 3 == 1) ? '0 : 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
            if (it[0]) begin
                go1(n);
                model(clr, set, 1, ec, fp, fv, lg);
                checks++; if (n !== 8) begin errors++; $display("FAIL rnd%0d_edge got=%0d exp=8", it, n); end
                checks++; if ({ec1, ffp1, ffv1, log1, pass1} !== {8'(ec), fp, fv, lg, ec == 0}) begin errors++;
                    $display("FAIL rnd%0d_dut1 got=%h exp=%h", it, {ec1, ffp1, ffv1, log1, pass1}, {8'(ec), fp, fv, lg, ec == 0}); end
            end else begin
                go2(n);
                model(clr, set, 3, ec, fp, fv, lg);
                checks++; if (n !== 36) begin errors++; $display("FAIL rnd%0d_edge got=%0d exp=36", it, n); end
                checks++; if ({ec2, ffp2, ffv2, log2, pass2} !== {8'(ec), fp, fv, lg, ec == 0}) begin errors++;
                    $display("FAIL rnd%0d_dut2 got=%h exp=%h", it, {ec2, ffp2, ffv2, log2, pass2}, {8'(ec), fp, fv, lg, ec == 0}); end
            end
        end
    endtask

    task automatic test_abort;
        int n, seen;
        clr = '0; set = '0;
        @(negedge clk); @(negedge clk); start1 = 1;
        @(posedge clk); #1 start1 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b exp=1", busy1); end
        @(negedge clk) abort = 1;
        @(posedge clk); #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy1); end
        @(negedge clk) abort = 0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (done1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        go1(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL abort_rerun_edge got=%0d exp=8", n); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass got=%b exp=1", pass1); end
    endtask

    task automatic test_start_abort_idle;
        @(negedge clk); @(negedge clk); start1 = 1; abort = 1;
        @(posedge clk); #1 start1 = 0; abort = 0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL start_abort_busy got=%b exp=0", busy1); end
    endtask

    task automatic test_back_to_back;
        int n;
        clr = '0; set = '0;
        @(negedge clk); @(negedge clk); start1 = 1;
        @(posedge clk); #1 start1 = 0;
        @(posedge clk);
        @(negedge clk) start1 = 1;
        @(posedge clk); #1 start1 = 0;
        n = 2;
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL restart_ignored_edge got=%0d exp=8", n); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL restart_pass got=%b exp=1", pass1); end
    endtask

    task automatic test_rst_mid;
        int n;
        clr = 7'b0000010; set = '0;
        @(negedge clk); @(negedge clk); start1 = 1;
        @(posedge clk); #1 start1 = 0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (ec1 !== 8'd1) begin errors++; $display("FAIL midrun_errcnt got=%0d exp=1", ec1); end
        @(negedge clk) rst = 1;
        #1;
        checks++; if ({a1, b1, busy1, done1, pass1, ec1, ffp1, ffv1, log1} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=0", {a1, b1, busy1, done1, pass1, ec1, ffp1, ffv1, log1}); end
        @(negedge clk) rst = 0;
        clr = '0;
        go1(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL rst_rerun_edge got=%0d exp=8", n); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL rst_rerun_pass got=%b exp=1", pass1); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_xor_stuck;
        test_params;
        test_random;
        test_abort;
        test_start_abort_idle;
        test_back_to_back;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
